// File: rtl/shiftreg_pair_ctrl.sv
// shiftreg_pair_ctrl
// Sequences an external 8-to-16 byte-pair shift register. Bytes arrive on a
// valid/ready handshake; each accepted byte pulses shift_enable so the
// register shifts eightbits in (first byte ends in [7:0], second in [15:8]).
// A completed word is offered downstream via word_valid/word_ready. Delivered
// words are counted, and a lone low byte is dropped after TIMEOUT_CYCLES idle
// cycles (0 disables the timeout).
//
// Ports:
//   clk2          rising-edge system clock
//   Reset         synchronous active-high reset
//   byte_in       incoming byte
//   byte_valid    byte_in valid this cycle
//   byte_ready    controller accepts byte_in this cycle
//   flush         synchronous discard of any partial or pending word
//   word_ready    downstream accepts the word this cycle
//   word_valid    shift register holds a complete word
//   shift_enable  shift strobe to the register (high only on byte accept)
//   eightbits     data to the register (copy of byte_in)
//   word_count    delivered word count, wraps modulo 2^CNT_W
//   timeout_err   one-cycle pulse when a partial byte is dropped
module shiftreg_pair_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             clk2,
  input  logic             Reset,
  input  logic [7:0]       byte_in,
  input  logic             byte_valid,
  output logic             byte_ready,
  input  logic             flush,
  input  logic             word_ready,
  output logic             word_valid,
  output logic             shift_enable,
  output logic [7:0]       eightbits,
  output logic [CNT_W-1:0] word_count,
  output logic             timeout_err
);

  localparam int unsigned TO_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] TO_MAX   = '1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HAVE_LOW = 2'd1,
    FULL     = 2'd2
  } state_e;

  state_e           state_q;
  logic [TO_W-1:0]  to_cnt_q;
  logic [TO_W-1:0]  to_cnt_d;
  logic [CNT_W-1:0] word_count_q;
  logic [CNT_W-1:0] word_count_d;
  logic             timeout_err_q;

  logic byte_accept;
  logic word_deliver;
  logic timeout_hit;

  // Handshake decode. In FULL a byte may only enter while the word is being
  // taken, so the register never overwrites an undelivered word.
  always_comb begin
    byte_ready   = !Reset && !flush && ((state_q != FULL) || word_ready);
    word_valid   = !Reset && !flush && (state_q == FULL);
    byte_accept  = byte_valid && byte_ready;
    word_deliver = word_valid && word_ready;
    shift_enable = byte_accept;
    eightbits    = byte_in;
  end

  // Saturating idle counter so a disabled or oversized timeout never wraps
  // back around and fires again.
  always_comb begin
    to_cnt_d     = (to_cnt_q == TO_MAX) ? to_cnt_q : to_cnt_q + 1'b1;
    timeout_hit  = (TIMEOUT_CYCLES != 0) && (to_cnt_d == TO_LIMIT);
    word_count_d = word_count_q + 1'b1;
  end

  always_ff @(posedge clk2) begin
    if (Reset) begin
      state_q       <= IDLE;
      to_cnt_q      <= '0;
      word_count_q  <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      timeout_err_q <= 1'b0;
      if (flush) begin
        state_q  <= IDLE;
        to_cnt_q <= '0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (byte_accept) begin
              state_q  <= HAVE_LOW;
              to_cnt_q <= '0;
            end
          end
          HAVE_LOW: begin
            // An accept preempts the timeout, so the two never coincide.
            if (byte_accept) begin
              state_q <= FULL;
            end else begin
              to_cnt_q <= to_cnt_d;
              if (timeout_hit) begin
                state_q       <= IDLE;
                timeout_err_q <= 1'b1;
              end
            end
          end
          FULL: begin
            if (word_deliver) begin
              word_count_q <= word_count_d;
              if (byte_accept) begin
                state_q  <= HAVE_LOW;
                to_cnt_q <= '0;
              end else begin
                state_q <= IDLE;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  always_comb begin
    word_count  = word_count_q;
    timeout_err = timeout_err_q;
  end

endmodule

// File: tb/tb_shiftreg_pair_ctrl.sv
// Directed bench for shiftreg_pair_ctrl (TIMEOUT_CYCLES=4, CNT_W=2). A local
// model of the 8-to-16 shift register is driven by the DUT's shift_enable and
// eightbits so that word contents can be compared with hand-computed values.
module tb_shiftreg_pair_ctrl;

  logic       clk2 = 1'b0;
  logic       Reset;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_ready;
  logic       flush;
  logic       word_ready;
  logic       word_valid;
  logic       shift_enable;
  logic [7:0] eightbits;
  logic [1:0] word_count;
  logic       timeout_err;

  logic [15:0] sr = '0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk2 = ~clk2;

  shiftreg_pair_ctrl #(
    .TIMEOUT_CYCLES(4),
    .CNT_W(2)
  ) dut (
    .clk2        (clk2),
    .Reset       (Reset),
    .byte_in     (byte_in),
    .byte_valid  (byte_valid),
    .byte_ready  (byte_ready),
    .flush       (flush),
    .word_ready  (word_ready),
    .word_valid  (word_valid),
    .shift_enable(shift_enable),
    .eightbits   (eightbits),
    .word_count  (word_count),
    .timeout_err (timeout_err)
  );

  // Stand-in for the external register: shifts new bytes in at the top.
  always @(posedge clk2) begin
    if (shift_enable === 1'b1) sr <= {eightbits, sr[15:8]};
  end

  typedef struct packed {
    logic        rst;
    logic        fl;
    logic        bv;
    logic [7:0]  bi;
    logic        wr;
    logic        br;
    logic        wv;
    logic        se;
    logic [1:0]  cnt;
    logic        te;
    logic [15:0] word;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, input logic fl, input logic bv,
                              input logic [7:0] bi, input logic wr,
                              input logic br, input logic wv, input logic se,
                              input logic [1:0] cnt, input logic te,
                              input logic [15:0] word);
    vec_t v;
    v.rst = rst; v.fl = fl; v.bv = bv; v.bi = bi; v.wr = wr;
    v.br = br; v.wv = wv; v.se = se; v.cnt = cnt; v.te = te; v.word = word;
    return v;
  endfunction

  task automatic chk(input string tag, input int idx, input string field,
                     input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] %s: got %0h expected %0h", tag, idx, field, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag, input int idx);
    Reset      = v.rst;
    flush      = v.fl;
    byte_valid = v.bv;
    byte_in    = v.bi;
    word_ready = v.wr;
    #1;
    chk(tag, idx, "byte_ready",   16'(byte_ready),   16'(v.br));
    chk(tag, idx, "word_valid",   16'(word_valid),   16'(v.wv));
    chk(tag, idx, "shift_enable", 16'(shift_enable), 16'(v.se));
    chk(tag, idx, "eightbits",    16'(eightbits),    16'(v.bi));
    chk(tag, idx, "word_count",   16'(word_count),   16'(v.cnt));
    chk(tag, idx, "timeout_err",  16'(timeout_err),  16'(v.te));
    if (v.wv) chk(tag, idx, "word", sr, v.word);
    @(posedge clk2);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // rst fl bv bi wr | br wv se cnt te word
    // reset state and idle
    vecs.push_back(mk(1,0,1,8'h00,0, 0,0,0,2'd0,0,16'h0000));
    vecs.push_back(mk(0,0,0,8'h00,0, 1,0,0,2'd0,0,16'h0000));
    // basic pair 0x34,0x12 -> 0x1234
    vecs.push_back(mk(0,0,1,8'h34,1, 1,0,1,2'd0,0,16'h0000));
    vecs.push_back(mk(0,0,1,8'h12,1, 1,0,1,2'd0,0,16'h0000));
    vecs.push_back(mk(0,0,0,8'h00,1, 1,1,0,2'd0,0,16'h1234));
    vecs.push_back(mk(0,0,0,8'h00,0, 1,0,0,2'd1,0,16'h0000));
    // backpressure on 0xBEEF for 5 cycles
    vecs.push_back(mk(0,0,1,8'hEF,0, 1,0,1,2'd1,0,16'h0000));
    vecs.push_back(mk(0,0,1,8'hBE,0, 1,0,1,2'd1,0,16'h0000));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(0,0,1,8'h55,0, 0,1,0,2'd1,0,16'hBEEF));
    vecs.push_back(mk(0,0,0,8'h00,1, 1,1,0,2'd1,0,16'hBEEF));
    vecs.push_back(mk(0,0,0,8'h00,0, 1,0,0,2'd2,0,16'h0000));
    // simultaneous drain of 0x5678 and accept of 0xAA
    vecs.push_back(mk(0,0,1,8'h78,0, 1,0,1,2'd2,0,16'h0000));
    vecs.push_back(mk(0,0,1,8'h56,0, 1,0,1,2'd2,0,16'h0000));
    vecs.push_back(mk(0,0,1,8'hAA,1, 1,1,1,2'd2,0,16'h5678));
    vecs.push_back(mk(0,0,1,8'hBB,0, 1,0,1,2'd3,0,16'h0000));
    vecs.push_back(mk(0,0,0,8'h00,0, 0,1,0,2'd3,0,16'hBBAA));
    vecs.push_back(mk(0,0,0,8'h00,1, 1,1,0,2'd3,0,16'hBBAA));
    vecs.push_back(mk(0,0,0,8'h00,0, 1,0,0,2'd0,0,16'h0000));
    // timeout: lone 0x11, 4 idle cycles in HAVE_LOW, pulse, then 0x22,0x33
    vecs.push_back(mk(0,0,1,8'h11,0, 1,0,1,2'd0,0,16'h0000));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(0,0,0,8'h00,0, 1,0,0,2'd0,0,16'h0000));
    vecs.push_back(mk(0,0,0,8'h00,0, 1,0,0,2'd0,1,16'h0000));
    vecs.push_back(mk(0,0,1,8'h22,0, 1,0,1,2'd0,0,16'h0000));
    vecs.push_back(mk(0,0,1,8'h33,0, 1,0,1,2'd0,0,16'h0000));
    vecs.push_back(mk(0,0,0,8'h00,1, 1,1,0,2'd0,0,16'h3322));
    vecs.push_back(mk(0,0,0,8'h00,0, 1,0,0,2'd1,0,16'h0000));
    // flush in HAVE_LOW
    vecs.push_back(mk(0,0,1,8'h44,0, 1,0,1,2'd1,0,16'h0000));
    vecs.push_back(mk(0,1,1,8'h99,1, 0,0,0,2'd1,0,16'h0000));
    vecs.push_back(mk(0,0,0,8'h00,0, 1,0,0,2'd1,0,16'h0000));
    // flush in FULL
    vecs.push_back(mk(0,0,1,8'h01,0, 1,0,1,2'd1,0,16'h0000));
    vecs.push_back(mk(0,0,1,8'h02,0, 1,0,1,2'd1,0,16'h0000));
    vecs.push_back(mk(0,1,1,8'h03,1, 0,0,0,2'd1,0,16'h0000));
    vecs.push_back(mk(0,0,0,8'h00,0, 1,0,0,2'd1,0,16'h0000));
    // Reset in HAVE_LOW; no timeout afterwards
    vecs.push_back(mk(0,0,1,8'h05,0, 1,0,1,2'd1,0,16'h0000));
    vecs.push_back(mk(1,0,1,8'h06,1, 0,0,0,2'd1,0,16'h0000));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(0,0,0,8'h00,0, 1,0,0,2'd0,0,16'h0000));

    Reset = 1'b1; flush = 1'b0; byte_valid = 1'b0; byte_in = '0; word_ready = 1'b0;
    repeat (2) @(posedge clk2);
    #1;

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], "tbl", i);

    // Long stall in FULL: word held, no timeout, bytes refused.
    run_vec(mk(0,0,1,8'hC3,0, 1,0,1,2'd0,0,16'h0000), "stall", 0);
    run_vec(mk(0,0,1,8'hD4,0, 1,0,1,2'd0,0,16'h0000), "stall", 1);
    for (int i = 0; i < 20; i++)
      run_vec(mk(0,0,1,8'h77,0, 0,1,0,2'd0,0,16'hD4C3), "stall", 2 + i);
    run_vec(mk(0,0,0,8'h00,1, 1,1,0,2'd0,0,16'hD4C3), "stall", 22);
    run_vec(mk(0,0,0,8'h00,0, 1,0,0,2'd1,0,16'h0000), "stall", 23);

    // Second byte one cycle before the timeout limit preempts it.
    run_vec(mk(0,0,1,8'h10,0, 1,0,1,2'd1,0,16'h0000), "late", 0);
    for (int i = 0; i < 3; i++)
      run_vec(mk(0,0,0,8'h00,0, 1,0,0,2'd1,0,16'h0000), "late", 1 + i);
    run_vec(mk(0,0,1,8'h20,0, 1,0,1,2'd1,0,16'h0000), "late", 4);
    for (int i = 0; i < 6; i++)
      run_vec(mk(0,0,0,8'h00,0, 0,1,0,2'd1,0,16'h2010), "late", 5 + i);
    run_vec(mk(0,0,0,8'h00,1, 1,1,0,2'd1,0,16'h2010), "late", 11);
    run_vec(mk(0,0,0,8'h00,0, 1,0,0,2'd2,0,16'h0000), "late", 12);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/shiftreg_pair_ctrl.md
Name: shiftreg_pair_ctrl

Overview:
Controller that sequences the 8-to-16 byte-pair shift register. It accepts a byte stream through a valid/ready handshake and drives that register's shift_enable and eightbits inputs. It presents each completed 16-bit word, formed from two bytes, to a downstream consumer through a valid/ready handshake. It also counts delivered words and drops a stale half-word after a programmable timeout.

Parameters:
TIMEOUT_CYCLES, 255, idle cycles allowed in HAVE_LOW before the partial byte is dropped; 0 disables the timeout.
CNT_W, 16, width of word_count.

Ports:
clk2  input  1  system clock; all state updates on rising edge
Reset  input  1  synchronous, active-high reset
byte_in  input  8  incoming byte
byte_valid  input  1  byte_in is valid this cycle
byte_ready  output  1  controller accepts byte_in this cycle
flush  input  1  synchronous discard of any partial or pending word
word_ready  input  1  downstream accepts the word this cycle
word_valid  output  1  the register's sixteenbits holds a complete word {second byte, first byte}
shift_enable  output  1  to shift register; high exactly on cycles a byte is accepted
eightbits  output  8  to shift register; combinational copy of byte_in
word_count  output  CNT_W  number of words delivered; wraps modulo 2^CNT_W
timeout_err  output  1  one-cycle pulse when a partial byte is dropped by timeout

Behaviour:
- Byte accept = byte_valid && byte_ready. Word delivery = word_valid && word_ready.
- shift_enable = byte accept. It is combinational and never high on a cycle where no byte is accepted.
- Data ordering: the first accepted byte lands in sixteenbits[7:0] and the second in [15:8], per the register's shift direction.
- States: IDLE, HAVE_LOW, FULL. Reset state is IDLE.
- IDLE: byte_ready=1, word_valid=0. On byte accept, go to HAVE_LOW and clear the timeout counter.
- HAVE_LOW: byte_ready=1, word_valid=0.
  - On byte accept, go to FULL. word_valid rises on the cycle after the second accept, aligned with the register update; latency is 1 cycle.
  - Otherwise the timeout counter increments. When TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES, go to IDLE and pulse timeout_err for 1 cycle.
- FULL: word_valid=1 and byte_ready=word_ready. The next byte may only shift in while the word is being taken.
  - Word delivery without byte accept: go to IDLE and increment word_count.
  - Word delivery with byte accept on the same cycle: go to HAVE_LOW, increment word_count, clear the timeout counter. The consumer samples the old word at that edge.
  - No delivery: stay in FULL. word_valid remains high and the word remains stable indefinitely, with no timeout in FULL.
- flush: highest priority after Reset. Next state is IDLE, and the timeout counter clears.
  - While flush is high, byte_ready=0, shift_enable=0, word_valid=0.
  - No word is counted and no timeout_err is raised. The shift register contents are not cleared; they are simply ignored.
- Reset: all state clears on the next rising edge of clk2, including mid-word.
  - Reset values: state IDLE, word_valid 0, timeout_err 0, word_count 0, timeout counter 0.
  - byte_ready reads 1 once Reset deasserts.
  - shift_enable is gated low while Reset is high.
- word_count wraps from 2^CNT_W-1 to 0 with no flag.
- The timeout counter is sized to hold TIMEOUT_CYCLES and saturates. It cannot wrap and re-fire.
- timeout_err and a byte accept never coincide, because an accept in HAVE_LOW preempts the timeout.

Test Plan:
- Reset, then bytes 0x34 and 0x12 on consecutive cycles, word_ready=1 → shift_enable high for 2 cycles; word_valid high the next cycle with sixteenbits=0x1234; word_count=1; back to IDLE.
- Backpressure: complete word 0xBEEF with word_ready=0 for 5 cycles and byte_valid=1 throughout → byte_ready=0 and shift_enable=0 for all 5 cycles; word stays 0xBEEF; delivered once when word_ready=1; word_count increments by 1.
- Simultaneous drain and accept: in FULL with word 0x5678, word_ready=1, byte_valid=1 with 0xAA on the same cycle → consumer gets 0x5678, state becomes HAVE_LOW, next byte 0xBB yields 0xBBAA.
- Timeout with TIMEOUT_CYCLES=4: one byte 0x11 then idle → timeout_err pulses exactly once, 4 cycles after entering HAVE_LOW; state IDLE; next pair 0x22, 0x33 yields 0x3322 and word_count unchanged by the drop.
- Flush in HAVE_LOW and in FULL → word_valid=0 next cycle, byte_ready low while flush is high, word_count unchanged; Reset asserted in HAVE_LOW behaves the same and also zeroes word_count.
- Wrap with CNT_W=2: deliver 5 words → word_count sequence 1, 2, 3, 0, 1.
